// File: rtl/onset_enumerator_pkg.sv
// rtl/onset_enumerator_pkg.sv - shared FSM state type and signature step function
package onset_enumerator_pkg;

    // Widest signature the step function can handle; SIG_W must not exceed it.
    localparam int SIG_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One signature update: rotate left by one within 'width' bits, then XOR
    // in the zero-extended minterm. Operands are carried at SIG_MAX_W bits and
    // the caller truncates the result back to its own width.
    function automatic logic [SIG_MAX_W-1:0] sig_step(
        input logic [SIG_MAX_W-1:0] sig,
        input logic [SIG_MAX_W-1:0] data,
        input int unsigned          width
    );
        logic [SIG_MAX_W-1:0] mask;
        logic [SIG_MAX_W-1:0] rot;
        mask = (width >= SIG_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        rot  = ((sig << 1) | (sig >> (width - 1))) & mask;
        return rot ^ (data & mask);
    endfunction

endpackage

// File: rtl/onset_enumerator_if.sv
// rtl/onset_enumerator_if.sv - onset minterm stream with valid/ready handshake
interface onset_enumerator_if #(
    parameter int N_IN = 16
);
    logic            m_valid;
    logic            m_ready;
    logic [N_IN-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/onset_enumerator.sv
// rtl/onset_enumerator.sv - sweeps all input vectors of a benchmark function and streams its onset
module onset_enumerator
    import onset_enumerator_pkg::*;
#(
    parameter int N_IN  = 16,  // 2..16
    parameter int SIG_W = 32   // N_IN..SIG_MAX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [N_IN-1:0]     dut_x,
    input  logic                dut_y,
    onset_enumerator_if.master  m,
    output logic [N_IN:0]       onset_count,
    output logic [SIG_W-1:0]    signature
);

    localparam logic [N_IN-1:0] CNT_LAST = '1;

    state_t          state_q;
    state_t          state_d;
    logic [N_IN-1:0] cnt_q;
    logic            advance;
    logic            accept;
    logic            last_vec;

    // Next state, handshake decode and outputs; the function output is
    // presented on the stream combinationally while sweeping.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        dut_x     = '0;
        m.m_valid = 1'b0;
        advance   = 1'b0;
        accept    = 1'b0;
        last_vec  = (cnt_q == CNT_LAST);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                busy      = 1'b1;
                dut_x     = cnt_q;
                m.m_valid = dut_y;
                accept    = dut_y & m.m_ready;
                // An offset vector never waits; an onset vector waits for ready.
                advance   = ~dut_y | m.m_ready;
                if (advance && last_vec) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m.m_data = dut_x;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Vector counter, onset count and signature; cleared on a new sweep and
    // otherwise held outside SWEEP so results remain readable afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            onset_count <= '0;
            signature   <= '0;
        end else if (state_q == ST_IDLE && start) begin
            cnt_q       <= '0;
            onset_count <= '0;
            signature   <= '0;
        end else begin
            if (advance) begin
                cnt_q <= cnt_q + N_IN'(1);
            end
            if (accept) begin
                onset_count <= onset_count + (N_IN+1)'(1);
                signature   <= SIG_W'(sig_step(SIG_MAX_W'(signature),
                                               SIG_MAX_W'(cnt_q),
                                               SIG_W));
            end
        end
    end

endmodule

// File: tb/tb_onset_enumerator.sv
// tb/tb_onset_enumerator.sv - randomized self-checking bench for onset_enumerator
module tb_onset_enumerator;

    localparam int N_IN  = 4;
    localparam int SIG_W = 32;
    localparam int NV    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [N_IN-1:0]  dut_x;
    logic             dut_y;
    logic [N_IN:0]    onset_count;
    logic [SIG_W-1:0] signature;
    logic [NV-1:0]    tt;

    int errors = 0;
    int checks = 0;
    bit rdy [0:255];

    onset_enumerator_if #(.N_IN(N_IN)) m_if ();

    onset_enumerator #(.N_IN(N_IN), .SIG_W(SIG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .dut_x       (dut_x),
        .dut_y       (dut_y),
        .m           (m_if.master),
        .onset_count (onset_count),
        .signature   (signature)
    );

    always #5 clk = ~clk;

    // Benchmark function as a truth table.
    always_comb dut_y = tt[dut_x];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_valid"}, 64'(m_if.m_valid), 64'd0);
        check({tag, "_x"},     64'(dut_x), 64'd0);
        check({tag, "_count"}, 64'(onset_count), 64'd0);
        check({tag, "_sig"},   64'(signature), 64'd0);
    endtask

    // rmode 0: always ready; 1: random ready; 2: ready low for three cycles on vector 7
    task automatic run_sweep(input logic [NV-1:0] table_in, input int rmode, input bit poke_start);
        int          mi;
        int          cyc;
        int          j;
        int          exp_cycles;
        int          exp_count;
        logic [31:0] exp_sig;

        tt = table_in;
        for (int k = 0; k < 256; k++) begin
            case (rmode)
                0:       rdy[k] = 1'b1;
                1:       rdy[k] = ($urandom_range(0, 2) != 0);
                default: rdy[k] = !(k >= 7 && k <= 9);
            endcase
        end

        // Reference: final results from the onset set, duration from the ready pattern.
        exp_count = 0;
        exp_sig   = 32'd0;
        for (int i = 0; i < NV; i++) begin
            if (table_in[i]) begin
                exp_count++;
                exp_sig = {exp_sig[30:0], exp_sig[31]} ^ 32'(i);
            end
        end
        j = 0;
        exp_cycles = 0;
        while (j < NV) begin
            if (!table_in[j] || rdy[exp_cycles]) j++;
            exp_cycles++;
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mi  = 0;
        cyc = 0;
        while (busy && cyc < 200) begin
            m_if.m_ready = rdy[cyc];
            start = poke_start && (cyc == 5);
            #1;
            if (mi < NV) begin
                check("sweep_x", 64'(dut_x), 64'(mi));
                check("sweep_valid", 64'(m_if.m_valid), 64'(table_in[mi]));
                if (table_in[mi]) check("sweep_data", 64'(m_if.m_data), 64'(mi));
                if (!table_in[mi] || rdy[cyc]) mi++;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("sweep_cycles", 64'(cyc), 64'(exp_cycles));
        check("sweep_final_vec", 64'(mi), 64'(NV));
        #1;
        check("done_pulse", 64'(done), 64'd1);
        check("done_valid", 64'(m_if.m_valid), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        check("onset_count", 64'(onset_count), 64'(exp_count));
        check("signature", 64'(signature), 64'(exp_sig));
        @(negedge clk);
        #1;
        check("idle_done", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("hold_count", 64'(onset_count), 64'(exp_count));
        check("hold_sig", 64'(signature), 64'(exp_sig));
    endtask

    initial begin
        int  guard;
        bit  seen_done;

        rst          = 1'b1;
        start        = 1'b0;
        tt           = '0;
        m_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;

        run_sweep(16'h8888, 0, 1'b0);   // x0&x1: onsets 3,7,11,15
        run_sweep(16'h0000, 0, 1'b0);   // empty onset
        run_sweep(16'hFFFF, 0, 1'b0);   // full onset, count reaches 16
        run_sweep(16'h8888, 2, 1'b1);   // stall on 7, start ignored mid-sweep
        for (int r = 0; r < 6; r++) begin
            run_sweep(16'($urandom), 1, 1'b1);
        end

        // Reset while sweeping vector 9.
        tt = 16'h8888;
        m_if.m_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (dut_x != 4'd9 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("reach_vec9", 64'(dut_x), 64'd9);
        check("mid_count", 64'(onset_count), 64'd2);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_idle_zero("mid_reset");
        @(posedge clk);
        #1;
        check_idle_zero("reset_over_start");
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("no_done_after_abort", 64'(seen_done), 64'd0);

        run_sweep(16'h8888, 0, 1'b0);   // clean sweep after abort

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
